// File: rtl/fft_bin_scheduler.sv
// Captures one multi-channel frame, then replays it once per DFT bin into a serial
// single-bin DFT core, stepping the twiddle address k*n mod N and tagging each result.
module fft_bin_scheduler #(
    parameter int X_WIDTH      = 16,
    parameter int CHANELS      = 2,
    parameter int FRAME_LENGTH = 3,
    parameter int BINS         = 2,
    localparam int AW = $clog2(FRAME_LENGTH),
    localparam int BW = (BINS > 1) ? $clog2(BINS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [CHANELS*X_WIDTH-1:0] s_x,
    output logic                       coral_valid,
    output logic [CHANELS*X_WIDTH-1:0] coral_x,
    output logic [AW-1:0]              tw_addr,
    input  logic                       coral_finish,
    output logic                       bin_valid,
    output logic [BW-1:0]              bin_idx,
    output logic                       frame_done,
    output logic                       sync_err
);

    localparam int              DW     = CHANELS * X_WIDTH;
    localparam logic [AW-1:0]   N_LAST = AW'(FRAME_LENGTH - 1);
    localparam logic [AW:0]     N_FULL = (AW + 1)'(FRAME_LENGTH);
    localparam logic [BW-1:0]   K_LAST = BW'(BINS - 1);

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t          state_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   n_reg;
    logic [AW-1:0]   addr_reg;
    logic [BW-1:0]   k_reg;
    logic            s_ready_reg;
    logic            coral_valid_reg;
    logic            bin_valid_reg;
    logic [BW-1:0]   bin_idx_reg;
    logic            frame_done_reg;
    logic            sync_err_reg;

    logic [DW-1:0]   mem [FRAME_LENGTH];
    logic [DW-1:0]   rd_data_reg;
    logic [AW-1:0]   rd_addr;

    logic            wr_en;
    logic            last_issue;
    logic            last_bin;
    logic [AW:0]     addr_sum;
    logic [AW-1:0]   addr_next;

    genvar gi;

    assign wr_en      = (state_reg == FILL) && s_valid && s_ready_reg;
    assign last_issue = (state_reg == RUN) && (n_reg == N_LAST);
    assign last_bin   = (k_reg == K_LAST);

    // Running k*n mod N: add k each sample, fold once since addr and k are both below N.
    assign addr_sum  = {1'b0, addr_reg} + (AW + 1)'(k_reg);
    assign addr_next = (addr_sum >= N_FULL) ? AW'(addr_sum - N_FULL) : addr_sum[AW-1:0];

    // Read address runs one sample ahead so the registered read lines up with n_reg.
    always_comb begin
        rd_addr = '0;
        if (state_reg == RUN && !last_issue) begin
            rd_addr = n_reg + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= s_x;
        end
        rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= FILL;
            wr_ptr_reg      <= '0;
            n_reg           <= '0;
            k_reg           <= '0;
            addr_reg        <= '0;
            s_ready_reg     <= 1'b0;
            coral_valid_reg <= 1'b0;
            bin_valid_reg   <= 1'b0;
            bin_idx_reg     <= '0;
            frame_done_reg  <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            bin_valid_reg  <= last_issue;
            frame_done_reg <= last_issue && last_bin;
            if (last_issue) begin
                bin_idx_reg <= k_reg;
            end
            if (coral_finish != last_issue) begin
                sync_err_reg <= 1'b1;
            end

            case (state_reg)
                FILL: begin
                    s_ready_reg     <= 1'b1;
                    coral_valid_reg <= 1'b0;
                    if (wr_en) begin
                        if (wr_ptr_reg == N_LAST) begin
                            wr_ptr_reg      <= '0;
                            n_reg           <= '0;
                            k_reg           <= '0;
                            addr_reg        <= '0;
                            state_reg       <= RUN;
                            s_ready_reg     <= 1'b0;
                            coral_valid_reg <= 1'b1;
                        end else begin
                            wr_ptr_reg <= wr_ptr_reg + AW'(1);
                        end
                    end
                end
                RUN: begin
                    s_ready_reg     <= 1'b0;
                    coral_valid_reg <= 1'b1;
                    if (n_reg == N_LAST) begin
                        n_reg    <= '0;
                        addr_reg <= '0;
                        if (last_bin) begin
                            k_reg           <= '0;
                            state_reg       <= FILL;
                            s_ready_reg     <= 1'b1;
                            coral_valid_reg <= 1'b0;
                        end else begin
                            k_reg <= k_reg + BW'(1);
                        end
                    end else begin
                        n_reg    <= n_reg + AW'(1);
                        addr_reg <= addr_next;
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    generate
        for (gi = 0; gi < CHANELS; gi++) begin : g_ch
            assign coral_x[gi*X_WIDTH +: X_WIDTH] =
                coral_valid_reg ? rd_data_reg[gi*X_WIDTH +: X_WIDTH] : '0;
        end
    endgenerate

    assign s_ready     = s_ready_reg;
    assign coral_valid = coral_valid_reg;
    assign tw_addr     = addr_reg;
    assign bin_valid   = bin_valid_reg;
    assign bin_idx     = bin_idx_reg;
    assign frame_done  = frame_done_reg;
    assign sync_err    = sync_err_reg;

endmodule

// File: tb/tb_fft_bin_scheduler.sv
// Directed bench for fft_bin_scheduler: two instances (N=4/BINS=4/CH=1 and N=3/BINS=2/CH=2),
// each driven by a small behavioural DFT core model with an integer twiddle ROM.
module tb_fft_bin_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic fault = 1'b0;
    int vectors     = 0;
    int miscompares = 0;

    // Instance A: N=4, BINS=4, one channel
    logic        s_valid_a = 1'b0, s_ready_a, coral_valid_a, coral_finish_a;
    logic        bin_valid_a, frame_done_a, sync_err_a;
    logic [15:0] s_x_a = '0, coral_x_a;
    logic [1:0]  tw_addr_a, bin_idx_a;

    // Instance B: N=3, BINS=2, two channels
    logic        s_valid_b = 1'b0, s_ready_b, coral_valid_b, coral_finish_b;
    logic        bin_valid_b, frame_done_b, sync_err_b;
    logic [31:0] s_x_b = '0, coral_x_b;
    logic [1:0]  tw_addr_b;
    logic [0:0]  bin_idx_b;

    fft_bin_scheduler #(.X_WIDTH(16), .CHANELS(1), .FRAME_LENGTH(4), .BINS(4)) u_dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_x(s_x_a),
        .coral_valid(coral_valid_a), .coral_x(coral_x_a), .tw_addr(tw_addr_a),
        .coral_finish(coral_finish_a), .bin_valid(bin_valid_a), .bin_idx(bin_idx_a),
        .frame_done(frame_done_a), .sync_err(sync_err_a)
    );

    fft_bin_scheduler #(.X_WIDTH(16), .CHANELS(2), .FRAME_LENGTH(3), .BINS(2)) u_dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_x(s_x_b),
        .coral_valid(coral_valid_b), .coral_x(coral_x_b), .tw_addr(tw_addr_b),
        .coral_finish(coral_finish_b), .bin_valid(bin_valid_b), .bin_idx(bin_idx_b),
        .frame_done(frame_done_b), .sync_err(sync_err_b)
    );

    // Twiddle ROMs: w = exp(-j*2*pi*a/N); N=3 scaled by 1000
    int cos4 [4] = '{1, 0, -1, 0};
    int sin4 [4] = '{0, -1, 0, 1};
    int cos3 [3] = '{1000, -500, -500};
    int sin3 [3] = '{0, -866, 866};

    // Stimulus and hand-computed DFT results
    int xa  [2][4] = '{'{1, 2, 3, 4}, '{4, 3, 2, 1}};
    int rea [2][4] = '{'{10, -2, -2, -2}, '{10, 2, 2, 2}};
    int ima [2][4] = '{'{0, 2, 0, -2}, '{0, -2, 0, 2}};
    int twa [16]   = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 2, 0, 2, 0, 3, 2, 1};
    int xb0 [2][3] = '{'{1, 2, 3}, '{-1, 0, 2}};
    int xb1 [2][3] = '{'{4, 5, 6}, '{7, 7, 7}};
    int reb [2][2][2] = '{'{'{6000, -1500}, '{15000, -1500}}, '{'{1000, -2000}, '{21000, 0}}};
    int imb [2][2][2] = '{'{'{0, 866}, '{0, 866}}, '{'{0, 1732}, '{0, 0}}};
    int twb [6]    = '{0, 0, 0, 0, 1, 2};

    // Core model A
    int   cnt_a = 0, acc_re_a = 0, acc_im_a = 0, re_a = 0, im_a = 0;
    int   pre_re_a, pre_im_a;
    logic vo_a = 1'b0, fin_dly_a = 1'b0, fin_raw_a;
    assign pre_re_a       = int'($signed(coral_x_a)) * cos4[tw_addr_a];
    assign pre_im_a       = int'($signed(coral_x_a)) * sin4[tw_addr_a];
    assign fin_raw_a      = coral_valid_a && (cnt_a == 3);
    assign coral_finish_a = fault ? fin_dly_a : fin_raw_a;

    always @(posedge clk) begin
        if (rst) begin
            cnt_a <= 0; acc_re_a <= 0; acc_im_a <= 0; vo_a <= 1'b0; fin_dly_a <= 1'b0;
        end else begin
            fin_dly_a <= fin_raw_a;
            vo_a      <= 1'b0;
            if (coral_valid_a) begin
                if (cnt_a == 3) begin
                    re_a <= acc_re_a + pre_re_a; im_a <= acc_im_a + pre_im_a;
                    acc_re_a <= 0; acc_im_a <= 0; cnt_a <= 0; vo_a <= 1'b1;
                end else begin
                    acc_re_a <= acc_re_a + pre_re_a; acc_im_a <= acc_im_a + pre_im_a;
                    cnt_a <= cnt_a + 1;
                end
            end
        end
    end

    // Core model B
    int   cnt_b = 0;
    int   acc_re_b [2] = '{0, 0}, acc_im_b [2] = '{0, 0}, re_b [2] = '{0, 0}, im_b [2] = '{0, 0};
    int   pre_re_b [2], pre_im_b [2];
    logic vo_b = 1'b0;
    assign coral_finish_b = coral_valid_b && (cnt_b == 2);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pre_re_b[i] = int'($signed(coral_x_b[16*i +: 16])) * cos3[tw_addr_b];
            pre_im_b[i] = int'($signed(coral_x_b[16*i +: 16])) * sin3[tw_addr_b];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            cnt_b <= 0; vo_b <= 1'b0;
            for (int i = 0; i < 2; i++) begin acc_re_b[i] <= 0; acc_im_b[i] <= 0; end
        end else begin
            vo_b <= 1'b0;
            if (coral_valid_b) begin
                if (cnt_b == 2) begin
                    cnt_b <= 0; vo_b <= 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        re_b[i] <= acc_re_b[i] + pre_re_b[i]; im_b[i] <= acc_im_b[i] + pre_im_b[i];
                        acc_re_b[i] <= 0; acc_im_b[i] <= 0;
                    end
                end else begin
                    cnt_b <= cnt_b + 1;
                    for (int i = 0; i < 2; i++) begin
                        acc_re_b[i] <= acc_re_b[i] + pre_re_b[i]; acc_im_b[i] <= acc_im_b[i] + pre_im_b[i];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Push frame f into A; optional idle gaps between samples, s_valid left at 'hold' for the run.
    task automatic fill_a(input int f, input bit gaps, input bit hold);
        bit skip = 1'b0;
        int i = 0;
        while (i < 4) begin
            if (gaps && skip) begin
                s_valid_a = 1'b0; s_x_a = 16'h7fff; skip = 1'b0;
            end else begin
                s_valid_a = 1'b1; s_x_a = 16'(xa[f][i]); i++; skip = 1'b1;
            end
            @(negedge clk);
        end
        s_valid_a = hold;
        s_x_a     = 16'h5a5a;
    endtask

    // Observe the 16 RUN cycles plus the first FILL cycle; optionally assert rst after cycle abort_at.
    task automatic check_run_a(input int f, input int abort_at);
        for (int c = 0; c <= 16; c++) begin
            bit bv;
            bv = (c >= 4) && (c % 4 == 0);
            if (c < 16) begin
                chk("a_coral_valid", coral_valid_a, 1);
                chk("a_tw_addr", tw_addr_a, twa[c]);
                chk("a_coral_x", coral_x_a, xa[f][c % 4]);
                chk("a_s_ready_run", s_ready_a, 0);
            end else begin
                chk("a_s_ready_end", s_ready_a, 1);
                chk("a_coral_valid_end", coral_valid_a, 0);
                chk("a_coral_x_idle", coral_x_a, 0);
                s_valid_a = 1'b0;
            end
            chk("a_bin_valid", bin_valid_a, bv);
            chk("a_frame_done", frame_done_a, (c == 16));
            if (bv) begin
                chk("a_bin_idx", bin_idx_a, c / 4 - 1);
                chk("a_core_vo", vo_a, 1);
                chk("a_re", re_a, rea[f][c / 4 - 1]);
                chk("a_im", im_a, ima[f][c / 4 - 1]);
            end
            if (c == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic fill_b(input int f);
        for (int i = 0; i < 3; i++) begin
            s_valid_b = 1'b1;
            s_x_b     = {16'(xb1[f][i]), 16'(xb0[f][i])};
            @(negedge clk);
        end
        s_valid_b = 1'b0;
        s_x_b     = '1;
    endtask

    // Ends on the first FILL cycle without advancing, so the next frame can start right there.
    task automatic check_run_b(input int f);
        for (int c = 0; c <= 6; c++) begin
            bit bv;
            logic [31:0] ex;
            bv = (c == 3) || (c == 6);
            if (c < 6) begin
                ex = {16'(xb1[f][c % 3]), 16'(xb0[f][c % 3])};
                chk("b_coral_valid", coral_valid_b, 1);
                chk("b_tw_addr", tw_addr_b, twb[c]);
                chk("b_coral_x", coral_x_b, ex);
            end
            chk("b_s_ready", s_ready_b, (c == 6));
            chk("b_bin_valid", bin_valid_b, bv);
            chk("b_frame_done", frame_done_b, (c == 6));
            if (bv) begin
                chk("b_bin_idx", bin_idx_b, c / 3 - 1);
                chk("b_core_vo", vo_b, 1);
                for (int ch = 0; ch < 2; ch++) begin
                    chk("b_re", re_b[ch], reb[f][ch][c / 3 - 1]);
                    chk("b_im", im_b[ch], imb[f][ch][c / 3 - 1]);
                end
            end
            if (c < 6) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset held two cycles
        @(negedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready_a, 0);
        chk("rst_coral_valid", coral_valid_a, 0);
        chk("rst_coral_x", coral_x_a, 0);
        chk("rst_tw_addr", tw_addr_a, 0);
        chk("rst_bin_valid", bin_valid_a, 0);
        chk("rst_bin_idx", bin_idx_a, 0);
        chk("rst_frame_done", frame_done_a, 0);
        chk("rst_sync_err", sync_err_a, 0);
        chk("rst_b_s_ready", s_ready_b, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready_a, 1);
        chk("post_rst_b_s_ready", s_ready_b, 1);

        // 2: continuous frame
        fill_a(0, 1'b0, 1'b0);
        check_run_a(0, -1);

        // 3: gapped fill, s_valid held high during RUN
        fill_a(0, 1'b1, 1'b1);
        check_run_a(0, -1);

        // 4: reset during bin 2, then a fresh frame
        fill_a(0, 1'b0, 1'b0);
        check_run_a(0, 9);
        chk("abort_coral_valid", coral_valid_a, 0);
        chk("abort_bin_valid", bin_valid_a, 0);
        chk("abort_frame_done", frame_done_a, 0);
        chk("abort_tw_addr", tw_addr_a, 0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_idle_bin_valid", bin_valid_a, 0);
            chk("abort_idle_frame_done", frame_done_a, 0);
            chk("abort_idle_coral_valid", coral_valid_a, 0);
        end
        chk("abort_s_ready", s_ready_a, 1);
        fill_a(1, 1'b0, 1'b0);
        check_run_a(1, -1);
        chk("sync_err_clean", sync_err_a, 0);

        // 5: finish delayed by one cycle
        fault = 1'b1;
        fill_a(0, 1'b0, 1'b0);
        check_run_a(0, -1);
        chk("sync_err_set", sync_err_a, 1);
        fault = 1'b0;
        repeat (5) @(negedge clk);
        chk("sync_err_sticky", sync_err_a, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("sync_err_cleared", sync_err_a, 0);
        @(negedge clk);
        chk("b_s_ready_idle", s_ready_b, 1);

        // 6: two back-to-back frames on the two-channel instance
        fill_b(0);
        check_run_b(0);
        fill_b(1);
        check_run_b(1);
        chk("b_sync_err", sync_err_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
